// File: rtl/riscv_csr_file.sv
// Machine-mode CSR register file: trap state, 64-bit mcycle/minstret counters,
// trap entry and mret sequencing, combinational read port for the CSR ALU.
module riscv_csr_file #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            csr_addr,
    input  logic                   csr_wen,
    input  logic [WORD_LENGTH-1:0] csr_wdata,
    output logic [WORD_LENGTH-1:0] csr_rdata,
    output logic                   csr_illegal,
    input  logic                   instr_retire,
    input  logic                   trap_valid,
    input  logic [WORD_LENGTH-1:0] trap_pc,
    input  logic [WORD_LENGTH-1:0] trap_cause,
    input  logic                   mret,
    output logic [WORD_LENGTH-1:0] trap_vector,
    output logic [WORD_LENGTH-1:0] epc
);
    localparam int unsigned CNT_W = 2 * WORD_LENGTH;
    localparam logic [WORD_LENGTH-1:0] ALIGN_MASK = ~WORD_LENGTH'(3);
    localparam logic [WORD_LENGTH-1:0] MTVEC_RST  = WORD_LENGTH'(RESET_MTVEC) & ALIGN_MASK;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic                   mie;
    logic                   mpie;
    logic [WORD_LENGTH-1:0] mtvec;
    logic [WORD_LENGTH-1:0] mscratch;
    logic [WORD_LENGTH-1:0] mepc;
    logic [WORD_LENGTH-1:0] mcause;
    logic [CNT_W-1:0]       mcycle;
    logic [CNT_W-1:0]       minstret;

    logic                   mapped;
    logic                   read_only;
    logic                   wr_ok;
    logic [WORD_LENGTH-1:0] mstatus_val;

    always_comb begin
        mstatus_val    = '0;
        mstatus_val[3] = mie;
        mstatus_val[7] = mpie;
    end

    // Address decode and read mux; reads always see pre-edge state
    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = mstatus_val;
            A_MTVEC:     csr_rdata = mtvec;
            A_MSCRATCH:  csr_rdata = mscratch;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
            A_MCYCLE:    csr_rdata = mcycle[WORD_LENGTH-1:0];
            A_MCYCLEH:   csr_rdata = mcycle[CNT_W-1:WORD_LENGTH];
            A_MINSTRET:  csr_rdata = minstret[WORD_LENGTH-1:0];
            A_MINSTRETH: csr_rdata = minstret[CNT_W-1:WORD_LENGTH];
            A_CYCLE: begin
                csr_rdata = mcycle[WORD_LENGTH-1:0];
                read_only = 1'b1;
            end
            A_CYCLEH: begin
                csr_rdata = mcycle[CNT_W-1:WORD_LENGTH];
                read_only = 1'b1;
            end
            A_INSTRET: begin
                csr_rdata = minstret[WORD_LENGTH-1:0];
                read_only = 1'b1;
            end
            A_INSTRETH: begin
                csr_rdata = minstret[CNT_W-1:WORD_LENGTH];
                read_only = 1'b1;
            end
            A_MHARTID: read_only = 1'b1;
            default:   mapped = 1'b0;
        endcase
    end

    assign csr_illegal = !mapped || (read_only && csr_wen);
    // A trap swallows any software write issued in the same cycle
    assign wr_ok       = csr_wen && !csr_illegal && !trap_valid;
    assign trap_vector = mtvec;
    assign epc         = mepc;

    // Trap state: trap entry beats mret, mret beats a write to mstatus
    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            if (trap_valid) begin
                mepc   <= trap_pc & ALIGN_MASK;
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_ok && csr_addr == A_MSTATUS) begin
                mie  <= csr_wdata[3];
                mpie <= csr_wdata[7];
            end
            if (wr_ok) begin
                case (csr_addr)
                    A_MTVEC:    mtvec    <= csr_wdata & ALIGN_MASK;
                    A_MSCRATCH: mscratch <= csr_wdata;
                    A_MEPC:     mepc     <= csr_wdata & ALIGN_MASK;
                    A_MCAUSE:   mcause   <= csr_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // Counters: a write to either half freezes that counter for the cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_ok && csr_addr == A_MCYCLE) begin
                mcycle[WORD_LENGTH-1:0] <= csr_wdata;
            end else if (wr_ok && csr_addr == A_MCYCLEH) begin
                mcycle[CNT_W-1:WORD_LENGTH] <= csr_wdata;
            end else begin
                mcycle <= mcycle + CNT_W'(1);
            end

            if (wr_ok && csr_addr == A_MINSTRET) begin
                minstret[WORD_LENGTH-1:0] <= csr_wdata;
            end else if (wr_ok && csr_addr == A_MINSTRETH) begin
                minstret[CNT_W-1:WORD_LENGTH] <= csr_wdata;
            end else if (instr_retire && !trap_valid) begin
                minstret <= minstret + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_riscv_csr_file.sv
// Self-checking bench for riscv_csr_file: directed scenarios plus a long
// randomized run checked against a behavioural CSR model.
module tb_riscv_csr_file;
    localparam logic [31:0] RMTVEC     = 32'h8000_0107;
    localparam logic [31:0] RMTVEC_EXP = 32'h8000_0104;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] csr_addr = '0;
    logic        csr_wen = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic        mret = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] epc;

    int total = 0;
    int bad   = 0;

    riscv_csr_file #(.WORD_LENGTH(32), .RESET_MTVEC(RMTVEC)) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .mret(mret), .trap_vector(trap_vector), .epc(epc)
    );

    always #50 clk = ~clk;

    logic [11:0] map_addrs [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                    12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};

    // Behavioural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] v;
        v = 32'(m_mie) * 32'd8 + 32'(m_mpie) * 32'd128;
        case (a)
            12'h300: return v;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_mcycle[31:0];
            12'hB80, 12'hC80: return m_mcycle[63:32];
            12'hB02, 12'hC02: return m_minstret[31:0];
            12'hB82, 12'hC82: return m_minstret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_illegal(input logic [11:0] a, input bit wen);
        bit mapped, ro;
        mapped = 1'b0;
        foreach (map_addrs[i]) if (map_addrs[i] == a) mapped = 1'b1;
        ro = (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) ||
             (a == 12'hC82) || (a == 12'hF14);
        return !mapped || (ro && wen);
    endfunction

    task automatic model_step();
        bit wr;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mtvec = RMTVEC_EXP;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_mcycle = 0; m_minstret = 0;
            return;
        end
        wr = csr_wen && !model_illegal(csr_addr, csr_wen) && !trap_valid;
        if (wr && csr_addr == 12'hB00)      m_mcycle = {m_mcycle[63:32], csr_wdata};
        else if (wr && csr_addr == 12'hB80) m_mcycle = {csr_wdata, m_mcycle[31:0]};
        else                                m_mcycle = m_mcycle + 64'd1;
        if (wr && csr_addr == 12'hB02)      m_minstret = {m_minstret[63:32], csr_wdata};
        else if (wr && csr_addr == 12'hB82) m_minstret = {csr_wdata, m_minstret[31:0]};
        else if (instr_retire && !trap_valid) m_minstret = m_minstret + 64'd1;
        if (trap_valid) begin
            m_mepc = trap_pc - (trap_pc % 4);
            m_mcause = trap_cause;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (mret) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (wr && csr_addr == 12'h300) begin
            m_mie = csr_wdata[3];
            m_mpie = csr_wdata[7];
        end
        if (wr && csr_addr == 12'h305) m_mtvec = csr_wdata - (csr_wdata % 4);
        if (wr && csr_addr == 12'h340) m_mscratch = csr_wdata;
        if (wr && csr_addr == 12'h341) m_mepc = csr_wdata - (csr_wdata % 4);
        if (wr && csr_addr == 12'h342) m_mcause = csr_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; csr_wen = 0; trap_valid = 0; mret = 0; instr_retire = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        idle();
        foreach (map_addrs[i]) begin
            logic [31:0] exp;
            exp = (map_addrs[i] == 12'h305) ? RMTVEC_EXP : 32'h0;
            csr_addr = map_addrs[i];
            #1;
            total++;
            if (csr_rdata !== exp || csr_illegal !== 1'b0) begin
                bad++;
                $display("FAIL reset_read[%h]: got %h ill=%b want %h ill=0",
                         map_addrs[i], csr_rdata, csr_illegal, exp);
            end
        end
        total++;
        if (trap_vector !== RMTVEC_EXP || epc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: tv=%h epc=%h want %h 0", trap_vector, epc, RMTVEC_EXP);
        end
    endtask

    task automatic test_rw();
        csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF; csr_wen = 1;
        tick();
        csr_wen = 0; #1;
        total++;
        if (csr_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL mscratch_rw: got %h want deadbeef", csr_rdata);
        end
        csr_addr = 12'hC00; csr_wdata = 32'h1234_5678; csr_wen = 1; #1;
        total++;
        if (csr_illegal !== 1'b1) begin
            bad++;
            $display("FAIL ro_write_illegal: got %b want 1", csr_illegal);
        end
        tick();
        csr_wen = 0; #1;
        total++;
        if (csr_rdata !== model_read(12'hC00) || csr_rdata === 32'h1234_5678) begin
            bad++;
            $display("FAIL ro_write_nochange: got %h want %h", csr_rdata, model_read(12'hC00));
        end
        csr_addr = 12'h7C0; #1;
        total++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_read: got ill=%b data=%h want ill=1 data=0", csr_illegal, csr_rdata);
        end
    endtask

    task automatic test_carry();
        csr_wen = 1; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
        tick();
        csr_addr = 12'hB80; csr_wdata = 32'h0;
        tick();
        csr_wen = 0;
        tick();
        csr_addr = 12'hB00; #1;
        total++;
        if (csr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL carry_lo: got %h want 0", csr_rdata);
        end
        csr_addr = 12'hB80; #1;
        total++;
        if (csr_rdata !== 32'h1) begin
            bad++;
            $display("FAIL carry_hi: got %h want 1", csr_rdata);
        end
    endtask

    task automatic test_trap_mret();
        csr_wen = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
        tick();
        csr_wen = 0; trap_valid = 1; trap_pc = 32'h104; trap_cause = 32'd11;
        tick();
        trap_valid = 0;
        csr_addr = 12'h341; #1;
        total++;
        if (csr_rdata !== 32'h104 || epc !== 32'h104) begin
            bad++;
            $display("FAIL trap_mepc: got %h epc=%h want 104", csr_rdata, epc);
        end
        csr_addr = 12'h342; #1;
        total++;
        if (csr_rdata !== 32'd11) begin
            bad++;
            $display("FAIL trap_mcause: got %h want b", csr_rdata);
        end
        csr_addr = 12'h300; #1;
        total++;
        if (csr_rdata !== 32'h80) begin
            bad++;
            $display("FAIL trap_mstatus: got %h want 80", csr_rdata);
        end
        mret = 1;
        tick();
        mret = 0; #1;
        total++;
        if (csr_rdata !== 32'h88) begin
            bad++;
            $display("FAIL mret_mstatus: got %h want 88", csr_rdata);
        end
    endtask

    task automatic test_trap_beats_wen();
        trap_valid = 1; trap_pc = 32'h206; trap_cause = 32'd2;
        csr_wen = 1; csr_addr = 12'h341; csr_wdata = 32'h500;
        tick();
        idle(); #1;
        total++;
        if (csr_rdata !== 32'h204 || epc !== 32'h204) begin
            bad++;
            $display("FAIL trap_vs_wen: got %h epc=%h want 204", csr_rdata, epc);
        end
    endtask

    task automatic test_minstret();
        rst = 1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            instr_retire = 1;
            trap_valid = (i == 2);
            trap_pc = 32'h40; trap_cause = 32'd3;
            tick();
        end
        idle();
        csr_addr = 12'hB02; #1;
        total++;
        if (csr_rdata !== 32'd4) begin
            bad++;
            $display("FAIL minstret_count: got %0d want 4", csr_rdata);
        end
        rst = 1; instr_retire = 1;
        tick();
        idle(); #1;
        total++;
        if (csr_rdata !== 32'd0) begin
            bad++;
            $display("FAIL minstret_reset: got %0d want 0", csr_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            trap_valid   = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 9) == 0);
            instr_retire = 1'($urandom_range(0, 1));
            csr_wen      = 1'($urandom_range(0, 1));
            csr_addr     = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                       : map_addrs[$urandom_range(0, 13)];
            csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            trap_pc      = $urandom;
            trap_cause   = $urandom;
            #1;
            total++;
            if (csr_rdata !== model_read(csr_addr) ||
                csr_illegal !== model_illegal(csr_addr, csr_wen)) begin
                bad++;
                $display("FAIL rand_read[%0d] addr=%h: got %h ill=%b want %h ill=%b", n, csr_addr,
                         csr_rdata, csr_illegal, model_read(csr_addr), model_illegal(csr_addr, csr_wen));
            end
            total++;
            if (trap_vector !== m_mtvec || epc !== m_mepc) begin
                bad++;
                $display("FAIL rand_vec[%0d]: got tv=%h epc=%h want %h %h", n,
                         trap_vector, epc, m_mtvec, m_mepc);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_rw();
        test_carry();
        test_trap_mret();
        test_trap_beats_wen();
        test_minstret();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
